// File: rtl/btm_pkg.sv
// Shared definitions for the approximate MAC datapath: default widths, accumulator
// FSM state encoding and the saturation constant helper.
package btm_pkg;

  localparam int unsigned DpDefault   = 19;
  localparam int unsigned DaccDefault = 24;
  localparam int unsigned NtWDefault  = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StAccum = 2'd1;
  localparam state_t StHold  = 2'd2;

  // All-ones value of a w-bit unsigned quantity, returned zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/btm_sat_add.sv
// Combinational unsigned saturating adder: clamps to all-ones when the sum
// carries out of Width bits and flags the clamp on sat_o.
module btm_sat_add
  import btm_pkg::*;
#(
  parameter int unsigned Width = DaccDefault
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             sat_o
);

  logic [Width:0] full;

  always_comb begin
    full  = {1'b0, a_i} + {1'b0, b_i};
    sat_o = full[Width];
    sum_o = sat_o ? Width'(sat_max(Width)) : full[Width-1:0];
  end

endmodule

// File: rtl/btm_accum.sv
// Frame accumulator behind the truncated multiplier: sums nterms unsigned products
// into a saturating accumulator and hands the result out over valid/ready.
module btm_accum
  import btm_pkg::*;
#(
  parameter int unsigned DP   = DpDefault,
  parameter int unsigned DACC = DaccDefault,
  parameter int unsigned NT_W = NtWDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [NT_W-1:0] nterms_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DP-1:0]   in_prod_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DACC-1:0] out_sum_o,
  output logic            out_sat_o,
  output logic            busy_o
);

  state_t            state_q, state_d;
  logic [DACC-1:0]   acc_q, acc_d;
  logic [NT_W-1:0]   cnt_q, cnt_d;
  logic              sat_q, sat_d;

  logic [DACC-1:0]   add_sum;
  logic              add_sat;

  btm_sat_add #(
    .Width (DACC)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (DACC'(in_prod_i)),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = nterms_i;
          // An empty frame goes straight to HOLD and reports a zero sum.
          state_d = (nterms_i != '0) ? StAccum : StHold;
        end
      end
      StAccum: begin
        if (in_valid_i) begin
          acc_d = add_sum;
          sat_d = sat_q | add_sat;
          cnt_d = cnt_q - NT_W'(1);
          if (cnt_q == NT_W'(1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready_i) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Sum and flag are only exposed while a result is being offered.
  always_comb begin
    in_ready_o  = (state_q == StAccum);
    out_valid_o = (state_q == StHold);
    out_sum_o   = out_valid_o ? acc_q : '0;
    out_sat_o   = out_valid_o & sat_q;
    busy_o      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_btm_accum.sv
// Randomised scoreboard bench for btm_accum: expected frame sums are queued at
// stimulus time and popped by a monitor whenever a result is transferred.
module tb_btm_accum;

  localparam int unsigned DP   = 19;
  localparam int unsigned DACC = 24;
  localparam int unsigned NT_W = 8;
  localparam logic [63:0] MaxSum = (64'd1 << DACC) - 64'd1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NT_W-1:0] nterms = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DP-1:0]   in_prod = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DACC-1:0] out_sum;
  logic            out_sat;
  logic            busy;

  btm_accum #(
    .DP   (DP),
    .DACC (DACC),
    .NT_W (NT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .nterms_i    (nterms),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_prod_i   (in_prod),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_sat_o   (out_sat),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DACC-1:0] sum;
    logic            sat;
  } exp_t;

  exp_t          sb[$];
  logic [DP-1:0] pv[256];
  int            inject_at = -1;
  bit            start_on_xfer = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per transfer and checks the held result is stable.
  initial begin
    bit              held;
    logic [DACC-1:0] h_sum;
    logic            h_sat;
    exp_t            e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        held = 1'b0;
      end else begin
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        if (held) begin
          chk("hold_sum_stable", 64'(out_sum), 64'(h_sum));
          chk("hold_sat_stable", 64'(out_sat), 64'(h_sat));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("out_sum", 64'(out_sum), 64'(e.sum));
            chk("out_sat", 64'(out_sat), 64'(e.sat));
          end
          held = 1'b0;
        end else begin
          held  = 1'b1;
          h_sum = out_sum;
          h_sat = out_sat;
        end
      end
    end
  end

  task automatic do_start(input int n);
    start  = 1'b1;
    nterms = NT_W'(n);
    @(posedge clk); #1;
    start  = 1'b0;
    nterms = NT_W'($urandom);
  endtask

  task automatic drive_prod(input logic [DP-1:0] p, input int gap);
    bit r;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_prod  = p;
    r = 1'b0;
    for (int k = 0; k < 50 && !r; k++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
    end
    if (!r) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_prod  = DP'($urandom);
  endtask

  // gap < 0 picks a random 0..2 cycle bubble before each product.
  task automatic run_frame(input int n, input int gap, input int hold);
    logic [63:0] s;
    exp_t        e;
    s = 64'd0;
    for (int i = 0; i < n; i++) s += 64'(pv[i]);
    e.sum = (s > MaxSum) ? DACC'(MaxSum) : DACC'(s);
    e.sat = (s > MaxSum);
    sb.push_back(e);
    do_start(n);
    for (int i = 0; i < n; i++) begin
      if (i == inject_at) begin
        start  = 1'b1;
        nterms = NT_W'(2);
      end
      drive_prod(pv[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
      start = 1'b0;
    end
    @(negedge clk);
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("hold_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    if (start_on_xfer) begin
      start  = 1'b1;
      nterms = NT_W'(3);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_sum", 64'(out_sum), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset with random inputs: every output must stay low.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start     = 1'($urandom);
      nterms    = NT_W'($urandom);
      in_valid  = 1'($urandom);
      in_prod   = DP'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_sat", 64'(out_sat), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic four-term frame, back-to-back products.
    pv[0] = 10; pv[1] = 20; pv[2] = 30; pv[3] = 40;
    run_frame(4, 0, 0);

    // Input stalls and output backpressure; start during the transfer is ignored.
    pv[0] = 5; pv[1] = 7; pv[2] = 9;
    start_on_xfer = 1'b1;
    run_frame(3, 2, 4);
    start_on_xfer = 1'b0;

    // Saturation: 40 full-scale products.
    for (int i = 0; i < 40; i++) pv[i] = DP'(524287);
    run_frame(40, 0, 1);

    // Empty frame.
    run_frame(0, 0, 0);

    // Asynchronous reset mid-frame discards the partial sum.
    do_start(5);
    drive_prod(DP'(3), 0);
    drive_prod(DP'(4), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    #3 rst_n = 1'b1;
    repeat (6) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    pv[0] = 8;
    run_frame(1, 0, 0);

    // start raised during ACCUM must not spawn a second frame.
    pv[0] = 1; pv[1] = 2; pv[2] = 3;
    inject_at = 1;
    run_frame(3, 1, 0);
    inject_at = -1;
    repeat (4) begin
      @(negedge clk);
      chk("no_spurious_frame", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;

    // Random frames, some long enough to saturate.
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = int'($urandom_range(28, 45));
        for (int i = 0; i < n; i++) pv[i] = DP'($urandom_range(380000, 524287));
      end else begin
        n = int'($urandom_range(0, 12));
        for (int i = 0; i < n; i++) pv[i] = DP'($urandom_range(0, 524287));
      end
      run_frame(n, -1, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
